// File: rtl/k_map_pkg.sv
// Shared types and constants for the k_map sweeper: FSM states, the vector count,
// the reference truth table and the settle-counter width.
package k_map_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int KMAP_VECTORS = 16;
  localparam logic [15:0] KMAP_DEFAULT_TT = 16'h2147;
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/kmap_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each input vector is held
// before the k_map output is sampled.
module kmap_settle_timer
  import k_map_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_value,
  input  logic                en,
  output logic [SETTLE_W-1:0] count,
  output logic                zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/k_map_sweeper.sv
// Drives the 4-input k_map cell through all 16 vectors, captures Y into a truth table
// and counts minterms. Optional expected-table comparator: KMAP_EXPECT_CHECK_EN.
module k_map_sweeper
  import k_map_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = KMAP_DEFAULT_TT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y_in,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  minterm_count
`ifdef KMAP_EXPECT_CHECK_EN
  ,
  output logic        match,
  output logic        mismatch
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]          LAST_IDX    = 4'(KMAP_VECTORS - 1);

  state_t               state;
  state_t               state_next;
  logic [3:0]           idx;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_zero;
  logic [SETTLE_W-1:0]  timer_count;
  logic                 accept;

  kmap_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .en         (timer_en),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_next = SAMPLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      SAMPLE: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // idx deliberately stays at 15 after a sweep; only the next accepted start rewinds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      truth_table   <= '0;
      minterm_count <= '0;
    end else if (accept) begin
      idx           <= '0;
      truth_table   <= '0;
      minterm_count <= '0;
    end else if (state == SAMPLE) begin
      truth_table[idx] <= y_in;
      minterm_count    <= minterm_count + {4'b0000, y_in};
      if (idx != LAST_IDX) begin
        idx <= idx + 4'd1;
      end
    end
  end

  assign {a_out, b_out, c_out, d_out} = idx;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef KMAP_EXPECT_CHECK_EN
  // In DONE the table already holds vector 15, so the compare sees the full result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match    <= 1'b0;
      mismatch <= 1'b0;
    end else if (accept) begin
      match    <= 1'b0;
      mismatch <= 1'b0;
    end else if (state == DONE) begin
      match    <= (truth_table == EXPECTED_TT);
      mismatch <= (truth_table != EXPECTED_TT);
    end
  end
`else
  logic unused_expected;
  assign unused_expected = ^EXPECTED_TT;
`endif

endmodule
